spi_mem_arbiter: RTL and testbench
==================================

# spi_mem_arbiter

Shares the single serial memory engine between the CU instruction-fetch path (PC-addressed ROM reads) and the data path (MAR-addressed RAM reads/writes). It latches one request at a time and drives the engine's start/write/address lines. It routes the chip-select choice (ROM or RAM) and returns read data and a one-cycle acknowledge to the winning requester. A watchdog aborts transactions whose engine never reports done.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64, max cycles in WAIT before abort; 0 disables watchdog
- ADDR_W, 16, address width on all ports

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset rst, asynchronous, active-high
- f_req  in  1  fetch request, level, held until f_ack
- f_addr  in  ADDR_W  fetch address (PC)
- f_ack  out  1  one-cycle pulse: fetch complete, f_rdata valid
- f_rdata  out  8  last fetched byte
- d_req  in  1  data request, level, held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address (MAR, zero-extended)
- d_wdata  in  8  write data
- d_ack  out  1  one-cycle pulse: data transaction complete
- d_rdata  out  8  last read byte (unchanged by writes)
- spi_start  out  1  level to engine, high for whole transaction
- spi_done  in  1  engine completion, sampled only in WAIT
- spi_write  out  1  latched d_we (0 for fetch)
- spi_addr  out  ADDR_W  latched address
- spi_wdata  out  8  latched write data
- spi_rdata  in  8  engine read data, valid when spi_done high
- sel_rom  out  1  fetch owns the bus (gates ROM chip select)
- sel_ram  out  1  data owns the bus (gates RAM chip select)
- busy  out  1  state != IDLE
- err  out  1  sticky watchdog-abort flag

## Operation
- States: IDLE, WAIT, ACK. Internal: owner (F/D), last_owner, timeout counter.
- IDLE: if neither req high, stay. If one high, grant it. If both high, grant the requester that is not last_owner (round-robin). On grant: latch addr, we (forced 0 for fetch), wdata into spi_* registers; set owner and last_owner; clear counter; go WAIT.
- WAIT: spi_start=1, sel_rom=(owner==F), sel_ram=(owner==D). Counter increments each cycle.
  - spi_done=1: capture spi_rdata into the owner's rdata (reads only), go ACK.
  - Counter reaches TIMEOUT_CYCLES (nonzero) without done: set err; owner rdata := 8'hFF on reads; go ACK.
  - spi_done and timeout in same cycle: done wins, no err.
- ACK: owner's ack=1 for exactly this cycle; spi_start, sel_* = 0; go IDLE.
- Requests arriving during WAIT/ACK are held pending (level), served from IDLE.
- A req dropped after grant does not cancel: transaction completes, ack still pulses.
- spi_done outside WAIT is ignored.
- Reset values: state IDLE, last_owner=D (fetch wins first tie), all acks/spi_start/spi_write/sel_*/busy/err = 0, spi_addr/spi_wdata/f_rdata/d_rdata = 0. err is cleared only by rst.
- Reset mid-transaction: immediate return to reset values; no ack is generated.

## Timing
- All outputs are registered; no combinational path from req to any output.
- req high in cycle 0 (IDLE) -> spi_start, sel_*, spi_addr valid from cycle 1.
- spi_done high in cycle n (n≥1) -> ack and rdata valid in cycle n+1; IDLE in n+2.
- Minimum request-to-ack latency 2 cycles; back-to-back grants every 3 cycles minimum.
- Requester must have req low in the cycle after ack, else it is a new request.
- Watchdog: abort ack in cycle TIMEOUT_CYCLES+1 after the grant cycle.
- Alternating service under continuous contention: F, D, F, D…

## Test plan
- Single fetch: f_req, f_addr=16'h0012; engine done 5 cycles later with rdata 8'hA5 -> sel_rom high cycles 1-5, f_ack one cycle at 6, f_rdata=8'hA5, spi_write=0.
- Data write: d_req, d_we=1, d_addr=16'h0040, d_wdata=8'h3C -> spi_write=1, spi_addr=16'h0040, spi_wdata=8'h3C, sel_ram high, d_ack pulse, d_rdata unchanged.
- Contention: f_req and d_req held high from reset, engine done 1 cycle after each start -> grant order F, D, F, D; one ack each per 3 cycles.
- Watchdog: TIMEOUT_CYCLES=4, d read, spi_done never -> d_ack at cycle 5, d_rdata=8'hFF, err=1, which stays set through later good transactions.
- Done/timeout collision: spi_done on the timeout cycle -> normal ack, err stays 0.
- Reset mid-WAIT: assert rst during WAIT -> all outputs 0 immediately, no ack. First tie after release is granted to fetch.

Source files
------------

// File: rtl/spi_mem_arbiter.sv
// Shares one serial memory engine between instruction fetch (ROM) and data access (RAM).
// One transaction in flight, round-robin on ties, watchdog aborts a stalled engine.
module spi_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ADDR_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [7:0]        f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [7:0]        d_wdata,
    output logic              d_ack,
    output logic [7:0]        d_rdata,
    output logic              spi_start,
    input  logic              spi_done,
    output logic              spi_write,
    output logic [ADDR_W-1:0] spi_addr,
    output logic [7:0]        spi_wdata,
    input  logic [7:0]        spi_rdata,
    output logic              sel_rom,
    output logic              sel_ram,
    output logic              busy,
    output logic              err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [1:0]        r_state;
    logic              r_owner_d;
    logic              r_last_d;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_f_ack;
    logic              r_d_ack;
    logic [7:0]        r_f_rdata;
    logic [7:0]        r_d_rdata;
    logic              r_spi_start;
    logic              r_spi_write;
    logic [ADDR_W-1:0] r_spi_addr;
    logic [7:0]        r_spi_wdata;
    logic              r_sel_rom;
    logic              r_sel_ram;
    logic              r_busy;
    logic              r_err;

    logic              w_pick_d;
    logic              w_timeout;
    logic [7:0]        w_rd;

    // On a tie the side that did not own the bus last time wins.
    assign w_pick_d  = d_req && (!f_req || !r_last_d);
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);
    assign w_rd      = spi_done ? spi_rdata : 8'hFF;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner_d   <= 1'b0;
            r_last_d    <= 1'b1;
            r_cnt       <= '0;
            r_f_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_f_rdata   <= '0;
            r_d_rdata   <= '0;
            r_spi_start <= 1'b0;
            r_spi_write <= 1'b0;
            r_spi_addr  <= '0;
            r_spi_wdata <= '0;
            r_sel_rom   <= 1'b0;
            r_sel_ram   <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_f_ack <= 1'b0;
            r_d_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (f_req || d_req) begin
                        r_state     <= S_WAIT;
                        r_owner_d   <= w_pick_d;
                        r_last_d    <= w_pick_d;
                        r_cnt       <= '0;
                        r_spi_addr  <= w_pick_d ? d_addr : f_addr;
                        r_spi_write <= w_pick_d & d_we;
                        if (w_pick_d) begin
                            r_spi_wdata <= d_wdata;
                        end
                        r_spi_start <= 1'b1;
                        r_sel_rom   <= !w_pick_d;
                        r_sel_ram   <= w_pick_d;
                        r_busy      <= 1'b1;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Done takes priority over a simultaneous watchdog expiry.
                    if (spi_done || w_timeout) begin
                        r_state     <= S_ACK;
                        r_spi_start <= 1'b0;
                        r_sel_rom   <= 1'b0;
                        r_sel_ram   <= 1'b0;
                        r_f_ack     <= !r_owner_d;
                        r_d_ack     <= r_owner_d;
                        if (!spi_done) begin
                            r_err <= 1'b1;
                        end
                        if (!r_spi_write) begin
                            if (r_owner_d) begin
                                r_d_rdata <= w_rd;
                            end else begin
                                r_f_rdata <= w_rd;
                            end
                        end
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign f_ack     = r_f_ack;
    assign d_ack     = r_d_ack;
    assign f_rdata   = r_f_rdata;
    assign d_rdata   = r_d_rdata;
    assign spi_start = r_spi_start;
    assign spi_write = r_spi_write;
    assign spi_addr  = r_spi_addr;
    assign spi_wdata = r_spi_wdata;
    assign sel_rom   = r_sel_rom;
    assign sel_ram   = r_sel_ram;
    assign busy      = r_busy;
    assign err       = r_err;
endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Bench for spi_mem_arbiter: engine model answers with addr^B7 after a programmable delay.
module tb_spi_mem_arbiter;
    localparam int TO = 6;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          f_req = 1'b0;
    logic [AW-1:0] f_addr = '0;
    logic          f_ack;
    logic [7:0]    f_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [7:0]    d_wdata = '0;
    logic          d_ack;
    logic [7:0]    d_rdata;
    logic          spi_start;
    logic          spi_done = 1'b0;
    logic          spi_write;
    logic [AW-1:0] spi_addr;
    logic [7:0]    spi_wdata;
    logic [7:0]    spi_rdata = '0;
    logic          sel_rom;
    logic          sel_ram;
    logic          busy;
    logic          err;

    always #5 clk = ~clk;

    spi_mem_arbiter #(.TIMEOUT_CYCLES(TO), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .spi_start(spi_start), .spi_done(spi_done), .spi_write(spi_write),
        .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata),
        .sel_rom(sel_rom), .sel_ram(sel_ram), .busy(busy), .err(err)
    );

    typedef struct packed {
        logic       is_f;
        logic [7:0] rdata;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         eng_done_at = 1;
    int         eng_w = 0;
    logic [7:0] exp_d = 8'h00;

    // Engine: done pulses in the eng_done_at-th WAIT cycle (0 = never).
    task automatic step();
        @(negedge clk);
        if (spi_start) eng_w++; else eng_w = 0;
        spi_done  = spi_start && (eng_done_at > 0) && (eng_w == eng_done_at);
        spi_rdata = spi_addr[7:0] ^ 8'hB7;
    endtask

    task automatic wait_ack(input int limit, output int cyc, output logic fa, output logic da,
                            output logic saw_rom, output logic saw_ram);
        cyc = 0; fa = 1'b0; da = 1'b0; saw_rom = 1'b0; saw_ram = 1'b0;
        while (cyc < limit && !fa && !da) begin
            step();
            cyc++;
            fa = f_ack;
            da = d_ack;
            saw_rom = saw_rom | sel_rom;
            saw_ram = saw_ram | sel_ram;
        end
    endtask

    task automatic test_reset();
        logic [55:0] v;
        rst = 1'b1;
        step();
        step();
        v = {f_ack, d_ack, spi_start, spi_write, sel_rom, sel_ram, busy, err,
             spi_addr, spi_wdata, f_rdata, d_rdata};
        total++;
        if (v !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", v); end
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        logic [5:0] got;
        logic [5:0] want;
        exp_t e;
        eng_done_at = 5;
        f_addr = 16'h0012;
        f_req = 1'b1;
        sb.push_back({1'b1, 8'h12 ^ 8'hB7});
        for (int k = 1; k <= 8; k++) begin
            step();
            got  = {sel_rom, sel_ram, spi_start, f_ack, d_ack, busy};
            want = {k <= 5, 1'b0, k <= 5, k == 6, 1'b0, k <= 6};
            total++;
            if (got !== want) begin bad++; $display("FAIL fetch_cycle%0d got=%b want=%b", k, got, want); end
            if (k == 3) begin
                total++;
                if ({spi_write, spi_addr} !== {1'b0, 16'h0012}) begin
                    bad++; $display("FAIL fetch_latch got=%b/%h want=0/0012", spi_write, spi_addr);
                end
            end
            if (f_ack) begin
                f_req = 1'b0;
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL fetch_sb got=empty want=entry"); end
                else begin
                    e = sb.pop_front();
                    total++;
                    if (f_rdata !== e.rdata) begin bad++; $display("FAIL fetch_rdata got=%h want=%h", f_rdata, e.rdata); end
                end
            end
        end
    endtask

    task automatic test_data_write();
        int cyc; logic fa, da, sr, sm;
        exp_t e;
        eng_done_at = 2;
        d_we = 1'b1; d_addr = 16'h0040; d_wdata = 8'h3C; d_req = 1'b1;
        sb.push_back({1'b0, exp_d});
        wait_ack(20, cyc, fa, da, sr, sm);
        d_req = 1'b0; d_we = 1'b0;
        total++;
        if ({fa, da} !== 2'b01 || cyc != 3) begin bad++; $display("FAIL dwr_ack got=%b@%0d want=01@3", {fa, da}, cyc); end
        total++;
        if ({spi_write, spi_addr, spi_wdata} !== {1'b1, 16'h0040, 8'h3C}) begin
            bad++; $display("FAIL dwr_latch got=%b/%h/%h want=1/0040/3c", spi_write, spi_addr, spi_wdata);
        end
        total++;
        if ({sr, sm} !== 2'b01) begin bad++; $display("FAIL dwr_sel got=%b want=01", {sr, sm}); end
        if (da) begin
            e = sb.pop_front();
            total++;
            if (d_rdata !== e.rdata) begin bad++; $display("FAIL dwr_rdata got=%h want=%h", d_rdata, e.rdata); end
        end
        step();
        total++;
        if ({d_ack, busy} !== 2'b00) begin bad++; $display("FAIL dwr_pulse got=%b want=00", {d_ack, busy}); end
    endtask

    task automatic test_read_at(input logic [15:0] a, input int done_at, input int want_cyc, input string nm);
        int cyc; logic fa, da, sr, sm;
        exp_t e;
        eng_done_at = done_at;
        d_we = 1'b0; d_addr = a; d_req = 1'b1;
        exp_d = a[7:0] ^ 8'hB7;
        sb.push_back({1'b0, exp_d});
        wait_ack(40, cyc, fa, da, sr, sm);
        d_req = 1'b0;
        total++;
        if ({fa, da} !== 2'b01 || cyc != want_cyc) begin
            bad++; $display("FAIL %s_ack got=%b@%0d want=01@%0d", nm, {fa, da}, cyc, want_cyc);
        end
        if (da) begin
            e = sb.pop_front();
            total++;
            if (d_rdata !== e.rdata) begin bad++; $display("FAIL %s_rdata got=%h want=%h", nm, d_rdata, e.rdata); end
        end
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL %s_err got=%b want=0", nm, err); end
        step();
    endtask

    task automatic test_contention();
        int last_cyc; int nack;
        exp_t e;
        last_cyc = 0; nack = 0;
        eng_done_at = 1;
        f_addr = 16'h0100; d_addr = 16'h0203; d_we = 1'b0;
        f_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sb.push_back({1'b1, 8'h00 ^ 8'hB7});
            sb.push_back({1'b0, 8'h03 ^ 8'hB7});
        end
        for (int k = 1; k <= 16 && nack < 4; k++) begin
            step();
            if (f_ack || d_ack) begin
                e = sb.pop_front();
                total++;
                if ({f_ack, d_ack} !== {e.is_f, !e.is_f}) begin
                    bad++; $display("FAIL rr_order%0d got=%b want=%b", nack, {f_ack, d_ack}, {e.is_f, !e.is_f});
                end
                total++;
                if ((e.is_f ? f_rdata : d_rdata) !== e.rdata) begin
                    bad++; $display("FAIL rr_rdata%0d got=%h want=%h", nack, e.is_f ? f_rdata : d_rdata, e.rdata);
                end
                total++;
                if (k - last_cyc != ((nack == 0) ? 2 : 3)) begin
                    bad++; $display("FAIL rr_gap%0d got=%0d want=%0d", nack, k - last_cyc, (nack == 0) ? 2 : 3);
                end
                last_cyc = k;
                nack++;
                if (nack == 4) begin f_req = 1'b0; d_req = 1'b0; end
            end
        end
        f_req = 1'b0; d_req = 1'b0;
        exp_d = 8'h03 ^ 8'hB7;
        total++;
        if (nack != 4) begin bad++; $display("FAIL rr_count got=%0d want=4", nack); end
        step();
    endtask

    task automatic test_watchdog();
        int cyc; logic fa, da, sr, sm;
        exp_t e;
        eng_done_at = 0;
        d_we = 1'b0; d_addr = 16'h0055; d_req = 1'b1;
        sb.push_back({1'b0, 8'hFF});
        wait_ack(40, cyc, fa, da, sr, sm);
        d_req = 1'b0;
        total++;
        if ({fa, da} !== 2'b01 || cyc != TO + 1) begin
            bad++; $display("FAIL wd_ack got=%b@%0d want=01@%0d", {fa, da}, cyc, TO + 1);
        end
        if (da) begin
            e = sb.pop_front();
            total++;
            if (d_rdata !== e.rdata) begin bad++; $display("FAIL wd_rdata got=%h want=%h", d_rdata, e.rdata); end
        end
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL wd_err got=%b want=1", err); end
        step();
        eng_done_at = 1;
        f_addr = 16'h0020; f_req = 1'b1;
        sb.push_back({1'b1, 8'h20 ^ 8'hB7});
        wait_ack(20, cyc, fa, da, sr, sm);
        f_req = 1'b0;
        total++;
        if ({fa, da} !== 2'b10 || cyc != 2) begin bad++; $display("FAIL wd_next_ack got=%b@%0d want=10@2", {fa, da}, cyc); end
        if (fa) begin
            e = sb.pop_front();
            total++;
            if (f_rdata !== e.rdata) begin bad++; $display("FAIL wd_next_rdata got=%h want=%h", f_rdata, e.rdata); end
        end
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL wd_sticky got=%b want=1", err); end
        step();
    endtask

    task automatic test_reset_mid_wait();
        int cyc; logic fa, da, sr, sm;
        logic [55:0] v;
        exp_t e;
        eng_done_at = 0;
        d_we = 1'b0; d_addr = 16'h0066; d_req = 1'b1;
        step(); step(); step();
        total++;
        if (spi_start !== 1'b1) begin bad++; $display("FAIL rmw_inwait got=%b want=1", spi_start); end
        rst = 1'b1;
        #1;
        v = {f_ack, d_ack, spi_start, spi_write, sel_rom, sel_ram, busy, err,
             spi_addr, spi_wdata, f_rdata, d_rdata};
        total++;
        if (v !== '0) begin bad++; $display("FAIL rmw_async got=%h want=0", v); end
        step();
        step();
        total++;
        if ({f_ack, d_ack, busy} !== 3'b000) begin bad++; $display("FAIL rmw_noack got=%b want=000", {f_ack, d_ack, busy}); end
        eng_done_at = 1;
        f_addr = 16'h0010; f_req = 1'b1;
        sb.push_back({1'b1, 8'h10 ^ 8'hB7});
        rst = 1'b0;
        wait_ack(20, cyc, fa, da, sr, sm);
        f_req = 1'b0; d_req = 1'b0;
        total++;
        if ({fa, da} !== 2'b10 || cyc != 2) begin bad++; $display("FAIL rmw_tie got=%b@%0d want=10@2", {fa, da}, cyc); end
        if (fa) begin
            e = sb.pop_front();
            total++;
            if (f_rdata !== e.rdata) begin bad++; $display("FAIL rmw_rdata got=%h want=%h", f_rdata, e.rdata); end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_data_write();
        test_read_at(16'h0077, 3, 4, "dread");
        test_read_at(16'h0031, TO, TO + 1, "collide");
        test_contention();
        test_watchdog();
        test_reset_mid_wait();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=hung want=finished");
        $fatal(1, "bench timeout");
    end
endmodule
